re_slot_scheduler: RTL and testbench
====================================

Name: re_slot_scheduler

Overview:
Slot-level controller that sequences the RE mapper over one PUSCH allocation. It latches the slot configuration and walks symbols Sym_Start..Sym_End. For each symbol it fires a start pulse to the DMRS generator or the FFT source and audits the mapper's write count. It waits for the mapper's symbol-done, then advances, and reports slot completion or errors.

Parameters:
SC_W, 11, width of subcarrier index/count fields
RB_W, 7, width of RB count
SYM_W, 4, width of symbol index
TOTAL_SC, 1200, subcarriers per symbol (allocation must fit)
MAX_RB, 100, largest legal N_rb
TIMEOUT, 4095, idle cycles allowed in RUN with no mapper write before abort

Ports:
CLK_RE  in  1  clock
RST_RE  in  1  asynchronous active-low reset
Cfg_Valid  in  1  configuration offered
Cfg_Ready  out  1  high only in IDLE
Cfg_N_sc  in  SC_W  first subcarrier
Cfg_N_rb  in  RB_W  RBs allocated
Cfg_Sym_Start  in  SYM_W  first symbol
Cfg_Sym_End  in  SYM_W  last symbol
Cfg_Dmrs_Map  in  14  bit i=1 means symbol i carries DMRS
Abort  in  1  kill current slot
Map_Wr_Valid  in  1  mapper wrote one RE this cycle
Map_Sym_Done  in  1  mapper finished current symbol
Dmrs_Start  out  1  1-cycle pulse: start DMRS symbol
Fft_Start  out  1  1-cycle pulse: start data symbol
Sym_Idx  out  SYM_W  symbol in progress
Sym_Is_Dmrs  out  1  Cfg_Dmrs_Map[Sym_Idx] of latched map
N_sc  out  SC_W  latched first subcarrier
N_rb  out  RB_W  latched RB count
Busy  out  1  state != IDLE
Slot_Done  out  1  1-cycle pulse: all symbols complete
Err_Cfg  out  1  1-cycle pulse: config rejected
Err_Count  out  1  1-cycle pulse: symbol write count != N_rb*12
Err_Timeout  out  1  1-cycle pulse: watchdog fired

Behaviour:
- Reset: state IDLE; all pulses 0; Busy 0; Sym_Idx, N_sc, N_rb, Sym_Is_Dmrs, write counter, watchdog 0; Cfg_Ready 1 after reset.
- Registered outputs only; no combinational path from inputs to outputs, except Cfg_Ready, which is decoded from state.
- States: IDLE, ISSUE, RUN, DONE.
- IDLE: Cfg_Valid & Cfg_Ready is an accept. The validity check is combinational on the inputs:
  - 1 <= N_rb <= MAX_RB
  - Sym_Start <= Sym_End <= 13
  - N_sc + N_rb*12 <= TOTAL_SC, computed in SC_W+1 bits
- Invalid config: Err_Cfg pulses the next cycle; remain in IDLE; latched registers unchanged.
- Valid config: latch all fields; Sym_Idx <= Sym_Start; go to ISSUE.
- ISSUE (one cycle): Dmrs_Start=1 if map[Sym_Idx], else Fft_Start=1. Clear the write counter and watchdog. Go to RUN.
  - The start pulse is therefore asserted the cycle after accept.
- RUN:
  - Counter increments on each Map_Wr_Valid and saturates at 2^SC_W-1.
  - Watchdog increments on each cycle without Map_Wr_Valid and clears on a write.
  - On Map_Sym_Done, compare the final count (including a Map_Wr_Valid in the same cycle) with N_rb*12. On mismatch, pulse Err_Count the next cycle; the slot continues regardless.
  - If Sym_Idx == Sym_End, go to DONE. Otherwise Sym_Idx+1 and go to ISSUE, so the next start pulse comes exactly 1 cycle after Map_Sym_Done.
  - Watchdog reaching TIMEOUT: pulse Err_Timeout, go to IDLE, no Slot_Done.
- DONE (one cycle): Slot_Done=1, then IDLE.
  - Cfg_Ready returns the cycle after DONE.
- Map_Sym_Done and Map_Wr_Valid outside RUN are ignored (not counted, no error).
- Abort: in any non-IDLE state, go to IDLE next cycle.
  - Abort has priority over Map_Sym_Done and the watchdog.
  - No Slot_Done and no error pulses.
  - A start pulse already asserted is not retracted.
  - Abort in IDLE has no effect.
- Sym_Start == Sym_End: single symbol; ISSUE, RUN, DONE.
- Reset asserted mid-slot: immediate return to reset values (asynchronous).

Decomposition:
- Shared package pusch_re_pkg holds:
  - state encoding
  - TOTAL_SC, MAX_RB, SC_PER_RB=12
  - symbols-per-slot constant 14
- One sub-module, re_sym_audit: write counter, watchdog and compare, with outputs count_err and timeout. The FSM stays in the top module.

Test Plan:
- Valid config: N_sc=0, N_rb=2, Start=2, End=4, map=14'b00000000000100. Mapper model gives 24 writes then Sym_Done per symbol. Expect Dmrs_Start at sym 2, Fft_Start at syms 3 and 4, each 1 cycle after the prior Sym_Done; Slot_Done 1 cycle after the sym-4 Sym_Done; no errors.
- Fit check: N_sc=1100, N_rb=9 (1208>1200) gives Err_Cfg, no start pulse, Busy=0. N_sc=1092, N_rb=9 (=1200) is accepted. N_rb=0 and N_rb=101 are rejected.
- Count error: N_rb=1, mapper writes 11 then Sym_Done gives an Err_Count pulse, and the next symbol still issues. A 12th write coincident with Sym_Done gives no error.
- Abort: raised in RUN on the 2nd symbol gives IDLE next cycle, Cfg_Ready=1, no Slot_Done. A new config is then accepted normally.
- Watchdog (TIMEOUT=16 override): no writes after Fft_Start gives an Err_Timeout pulse when the watchdog reaches 16, then IDLE.
- Reset mid-RUN, then release: all outputs at reset values; a stray Map_Sym_Done in IDLE is ignored.

Source files
------------

// File: rtl/pusch_re_pkg.sv
// Shared constants and FSM state encoding for the PUSCH RE-mapping control path.
package pusch_re_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int RE_TOTAL_SC   = 1200;
  localparam int RE_MAX_RB     = 100;
  localparam int SC_PER_RB     = 12;
  localparam int SYMS_PER_SLOT = 14;

endpackage

// File: rtl/re_sym_audit.sv
// Per-symbol audit: saturating write counter, no-write watchdog and final count compare.
module re_sym_audit
  import pusch_re_pkg::*;
#(
  parameter int SC_W    = 11,
  parameter int TIMEOUT = 4095
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            wr,
  input  logic            sym_done,
  input  logic [SC_W-1:0] exp_cnt,
  output logic            count_err,
  output logic            timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [SC_W-1:0] wr_cnt;
  logic [SC_W-1:0] cnt_final;
  logic [WD_W-1:0] wdog;

  // A write in the same cycle as sym_done still belongs to this symbol.
  assign cnt_final = (wr && (wr_cnt != '1)) ? wr_cnt + SC_W'(1) : wr_cnt;
  assign count_err = en && sym_done && (cnt_final != exp_cnt);
  assign timeout   = en && !wr && (wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      wdog   <= '0;
    end else if (clr) begin
      wr_cnt <= '0;
      wdog   <= '0;
    end else if (en) begin
      wr_cnt <= cnt_final;
      wdog   <= wr ? '0 : wdog + WD_W'(1);
    end
  end

endmodule

// File: rtl/re_slot_scheduler.sv
// Slot-level sequencer for the RE mapper over one PUSCH allocation.
// state | meaning
// IDLE  | waiting for a configuration, Cfg_Ready high
// ISSUE | one cycle, start pulse for the current symbol
// RUN   | mapper writing current symbol, audited
// DONE  | one cycle, Slot_Done pulse
module re_slot_scheduler
  import pusch_re_pkg::*;
#(
  parameter int SC_W     = 11,
  parameter int RB_W     = 7,
  parameter int SYM_W    = 4,
  parameter int TOTAL_SC = RE_TOTAL_SC,
  parameter int MAX_RB   = RE_MAX_RB,
  parameter int TIMEOUT  = 4095
) (
  input  logic                     CLK_RE,
  input  logic                     RST_RE,
  input  logic                     Cfg_Valid,
  output logic                     Cfg_Ready,
  input  logic [SC_W-1:0]          Cfg_N_sc,
  input  logic [RB_W-1:0]          Cfg_N_rb,
  input  logic [SYM_W-1:0]         Cfg_Sym_Start,
  input  logic [SYM_W-1:0]         Cfg_Sym_End,
  input  logic [SYMS_PER_SLOT-1:0] Cfg_Dmrs_Map,
  input  logic                     Abort,
  input  logic                     Map_Wr_Valid,
  input  logic                     Map_Sym_Done,
  output logic                     Dmrs_Start,
  output logic                     Fft_Start,
  output logic [SYM_W-1:0]         Sym_Idx,
  output logic                     Sym_Is_Dmrs,
  output logic [SC_W-1:0]          N_sc,
  output logic [RB_W-1:0]          N_rb,
  output logic                     Busy,
  output logic                     Slot_Done,
  output logic                     Err_Cfg,
  output logic                     Err_Count,
  output logic                     Err_Timeout
);

  localparam int FIT_W = SC_W + 1;

  logic [1:0]               state, state_nx;
  logic [SYM_W-1:0]         sym_nx, sym_inc, sym_end;
  logic                     dmrs_nx;
  logic [SYMS_PER_SLOT-1:0] dmrs_map;
  logic                     accept, cfg_ok, latch_cfg;
  logic                     err_cfg_nx, err_cnt_nx, err_to_nx;
  logic [FIT_W-1:0]         fit_sum;
  logic [SC_W-1:0]          exp_cnt;
  logic                     count_err, timeout;

  assign Cfg_Ready = (state == ST_IDLE);
  assign accept    = Cfg_Valid && Cfg_Ready;

  // Fit sum is one bit wider than the subcarrier field so it cannot wrap.
  assign fit_sum = FIT_W'(Cfg_N_sc) + FIT_W'(Cfg_N_rb) * FIT_W'(SC_PER_RB);
  assign cfg_ok  = (Cfg_N_rb != '0) && (Cfg_N_rb <= RB_W'(MAX_RB)) &&
                   (Cfg_Sym_Start <= Cfg_Sym_End) &&
                   (Cfg_Sym_End <= SYM_W'(SYMS_PER_SLOT - 1)) &&
                   (fit_sum <= FIT_W'(TOTAL_SC));

  assign exp_cnt = SC_W'(N_rb) * SC_W'(SC_PER_RB);
  assign sym_inc = Sym_Idx + SYM_W'(1);

  always_comb begin
    state_nx   = state;
    sym_nx     = Sym_Idx;
    dmrs_nx    = Sym_Is_Dmrs;
    latch_cfg  = 1'b0;
    err_cfg_nx = 1'b0;
    err_cnt_nx = 1'b0;
    err_to_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && cfg_ok) begin
          state_nx  = ST_ISSUE;
          sym_nx    = Cfg_Sym_Start;
          dmrs_nx   = Cfg_Dmrs_Map[Cfg_Sym_Start];
          latch_cfg = 1'b1;
        end else if (accept) begin
          err_cfg_nx = 1'b1;
        end
      end
      ST_ISSUE: state_nx = ST_RUN;
      ST_RUN: begin
        if (Map_Sym_Done) begin
          err_cnt_nx = count_err;
          if (Sym_Idx == sym_end) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_ISSUE;
            sym_nx   = sym_inc;
            dmrs_nx  = dmrs_map[sym_inc];
          end
        end else if (timeout) begin
          state_nx  = ST_IDLE;
          err_to_nx = 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    // Abort outranks symbol completion and the watchdog, and suppresses their pulses.
    if (Abort && (state != ST_IDLE)) begin
      state_nx   = ST_IDLE;
      sym_nx     = Sym_Idx;
      dmrs_nx    = Sym_Is_Dmrs;
      err_cnt_nx = 1'b0;
      err_to_nx  = 1'b0;
    end
  end

  always_ff @(posedge CLK_RE or negedge RST_RE) begin
    if (!RST_RE) begin
      state       <= ST_IDLE;
      Sym_Idx     <= '0;
      Sym_Is_Dmrs <= 1'b0;
      N_sc        <= '0;
      N_rb        <= '0;
      sym_end     <= '0;
      dmrs_map    <= '0;
      Busy        <= 1'b0;
      Dmrs_Start  <= 1'b0;
      Fft_Start   <= 1'b0;
      Slot_Done   <= 1'b0;
      Err_Cfg     <= 1'b0;
      Err_Count   <= 1'b0;
      Err_Timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      Sym_Idx     <= sym_nx;
      Sym_Is_Dmrs <= dmrs_nx;
      Busy        <= (state_nx != ST_IDLE);
      Dmrs_Start  <= (state_nx == ST_ISSUE) && dmrs_nx;
      Fft_Start   <= (state_nx == ST_ISSUE) && !dmrs_nx;
      Slot_Done   <= (state_nx == ST_DONE);
      Err_Cfg     <= err_cfg_nx;
      Err_Count   <= err_cnt_nx;
      Err_Timeout <= err_to_nx;
      if (latch_cfg) begin
        N_sc     <= Cfg_N_sc;
        N_rb     <= Cfg_N_rb;
        sym_end  <= Cfg_Sym_End;
        dmrs_map <= Cfg_Dmrs_Map;
      end
    end
  end

  re_sym_audit #(
    .SC_W    (SC_W),
    .TIMEOUT (TIMEOUT)
  ) u_audit (
    .clk       (CLK_RE),
    .rst_n     (RST_RE),
    .clr       (state == ST_ISSUE),
    .en        (state == ST_RUN),
    .wr        (Map_Wr_Valid),
    .sym_done  (Map_Sym_Done),
    .exp_cnt   (exp_cnt),
    .count_err (count_err),
    .timeout   (timeout)
  );

endmodule

// File: tb/tb_re_slot_scheduler.sv
// Directed bench for re_slot_scheduler with a cycle-stamped pulse scoreboard.
module tb_re_slot_scheduler;

  logic        CLK_RE;
  logic        RST_RE;
  logic        Cfg_Valid;
  logic        Cfg_Ready;
  logic [10:0] Cfg_N_sc;
  logic [6:0]  Cfg_N_rb;
  logic [3:0]  Cfg_Sym_Start;
  logic [3:0]  Cfg_Sym_End;
  logic [13:0] Cfg_Dmrs_Map;
  logic        Abort;
  logic        Map_Wr_Valid;
  logic        Map_Sym_Done;
  logic        Dmrs_Start;
  logic        Fft_Start;
  logic [3:0]  Sym_Idx;
  logic        Sym_Is_Dmrs;
  logic [10:0] N_sc;
  logic [6:0]  N_rb;
  logic        Busy;
  logic        Slot_Done;
  logic        Err_Cfg;
  logic        Err_Count;
  logic        Err_Timeout;

  re_slot_scheduler #(.TIMEOUT(16)) dut (
    .CLK_RE        (CLK_RE),
    .RST_RE        (RST_RE),
    .Cfg_Valid     (Cfg_Valid),
    .Cfg_Ready     (Cfg_Ready),
    .Cfg_N_sc      (Cfg_N_sc),
    .Cfg_N_rb      (Cfg_N_rb),
    .Cfg_Sym_Start (Cfg_Sym_Start),
    .Cfg_Sym_End   (Cfg_Sym_End),
    .Cfg_Dmrs_Map  (Cfg_Dmrs_Map),
    .Abort         (Abort),
    .Map_Wr_Valid  (Map_Wr_Valid),
    .Map_Sym_Done  (Map_Sym_Done),
    .Dmrs_Start    (Dmrs_Start),
    .Fft_Start     (Fft_Start),
    .Sym_Idx       (Sym_Idx),
    .Sym_Is_Dmrs   (Sym_Is_Dmrs),
    .N_sc          (N_sc),
    .N_rb          (N_rb),
    .Busy          (Busy),
    .Slot_Done     (Slot_Done),
    .Err_Cfg       (Err_Cfg),
    .Err_Count     (Err_Count),
    .Err_Timeout   (Err_Timeout)
  );

  // Pulse vector bits: Dmrs, Fft, Slot_Done, Err_Cfg, Err_Count, Err_Timeout.
  localparam logic [5:0] P_DMRS = 6'b100000;
  localparam logic [5:0] P_FFT  = 6'b010000;
  localparam logic [5:0] P_DONE = 6'b001000;
  localparam logic [5:0] P_ECFG = 6'b000100;
  localparam logic [5:0] P_ECNT = 6'b000010;
  localparam logic [5:0] P_ETO  = 6'b000001;

  typedef struct {
    logic [5:0] vec;
    int         sym;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial CLK_RE = 1'b0;
  always #5 CLK_RE = ~CLK_RE;
  always @(posedge CLK_RE) cyc <= cyc + 1;

  task automatic push(input logic [5:0] v, input int s, input int c);
    exp_t e;
    e.vec = v;
    e.sym = s;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one config for one cycle; the resulting pulse is due one cycle later.
  task automatic cfg_send(input int sc, input int rb, input int s, input int e,
                          input logic [13:0] map, input logic [5:0] v, input int es);
    Cfg_N_sc      = 11'(sc);
    Cfg_N_rb      = 7'(rb);
    Cfg_Sym_Start = 4'(s);
    Cfg_Sym_End   = 4'(e);
    Cfg_Dmrs_Map  = map;
    Cfg_Valid     = 1'b1;
    push(v, es, cyc + 1);
    @(posedge CLK_RE); #1;
    Cfg_Valid = 1'b0;
  endtask

  // Mapper model for one symbol, entered during the ISSUE cycle.
  task automatic do_symbol(input int nwr, input bit coinc, input logic [5:0] v, input int s);
    @(posedge CLK_RE); #1;
    for (int i = 0; i < nwr; i++) begin
      Map_Wr_Valid = 1'b1;
      if (coinc && (i == nwr - 1)) begin
        Map_Sym_Done = 1'b1;
        push(v, s, cyc + 1);
      end
      @(posedge CLK_RE); #1;
    end
    Map_Wr_Valid = 1'b0;
    if (!coinc) begin
      Map_Sym_Done = 1'b1;
      push(v, s, cyc + 1);
      @(posedge CLK_RE); #1;
    end
    Map_Sym_Done = 1'b0;
  endtask

  logic [5:0] mon_vec;
  exp_t       mon_exp;

  initial begin
    forever begin
      @(negedge CLK_RE);
      mon_vec = {Dmrs_Start, Fft_Start, Slot_Done, Err_Cfg, Err_Count, Err_Timeout};
      if (mon_vec != 6'b0) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_pulse: observed %b at cycle %0d expected no pulse", mon_vec, cyc);
        end
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          checks++;
          assert (mon_vec === mon_exp.vec) else begin
            errors++;
            $error("FAIL pulse_vec: observed %b expected %b (cycle %0d)", mon_vec, mon_exp.vec, cyc);
          end
          checks++;
          assert (cyc === mon_exp.cyc) else begin
            errors++;
            $error("FAIL pulse_cycle: observed %0d expected %0d", cyc, mon_exp.cyc);
          end
          if ((mon_exp.vec & (P_DMRS | P_FFT)) != 6'b0) begin
            checks++;
            assert (int'(Sym_Idx) === mon_exp.sym) else begin
              errors++;
              $error("FAIL start_sym: observed %0d expected %0d", Sym_Idx, mon_exp.sym);
            end
            checks++;
            assert (Sym_Is_Dmrs === mon_exp.vec[5]) else begin
              errors++;
              $error("FAIL sym_is_dmrs: observed %b expected %b", Sym_Is_Dmrs, mon_exp.vec[5]);
            end
          end
        end
      end
    end
  end

  initial begin
    RST_RE        = 1'b0;
    Cfg_Valid     = 1'b0;
    Cfg_N_sc      = '0;
    Cfg_N_rb      = '0;
    Cfg_Sym_Start = '0;
    Cfg_Sym_End   = '0;
    Cfg_Dmrs_Map  = '0;
    Abort         = 1'b0;
    Map_Wr_Valid  = 1'b0;
    Map_Sym_Done  = 1'b0;
    repeat (3) @(posedge CLK_RE);
    #1;
    chk("rst_ready", Cfg_Ready, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_sym_idx", Sym_Idx, 0);
    chk("rst_n_sc", N_sc, 0);
    chk("rst_n_rb", N_rb, 0);
    RST_RE = 1'b1;
    @(posedge CLK_RE); #1;

    // Three-symbol slot, DMRS on symbol 2 only.
    cfg_send(0, 2, 2, 4, 14'b00000000000100, P_DMRS, 2);
    chk("run_busy", Busy, 1);
    chk("run_ready", Cfg_Ready, 0);
    chk("run_n_rb", N_rb, 2);
    do_symbol(24, 0, P_FFT, 3);
    do_symbol(24, 0, P_FFT, 4);
    do_symbol(24, 0, P_DONE, 4);
    chk("done_ready", Cfg_Ready, 0);
    @(posedge CLK_RE); #1;
    chk("post_done_ready", Cfg_Ready, 1);
    chk("post_done_busy", Busy, 0);

    // Config validity boundaries.
    cfg_send(1100, 9, 0, 0, 14'b0, P_ECFG, 0);
    chk("bad_fit_busy", Busy, 0);
    chk("bad_fit_n_sc_kept", N_sc, 0);
    chk("bad_fit_n_rb_kept", N_rb, 2);
    cfg_send(0, 0, 0, 0, 14'b0, P_ECFG, 0);
    cfg_send(0, 101, 0, 0, 14'b0, P_ECFG, 0);
    cfg_send(0, 1, 5, 4, 14'b0, P_ECFG, 0);
    cfg_send(0, 1, 0, 14, 14'b0, P_ECFG, 0);
    cfg_send(1092, 9, 0, 0, 14'b0, P_FFT, 0);
    chk("fit_n_sc", N_sc, 1092);
    chk("fit_n_rb", N_rb, 9);
    do_symbol(108, 0, P_DONE, 0);
    @(posedge CLK_RE); #1;

    // Short symbol flags a count error but the slot carries on.
    cfg_send(0, 1, 5, 6, 14'b0, P_FFT, 5);
    do_symbol(11, 0, P_FFT | P_ECNT, 6);
    do_symbol(12, 1, P_DONE, 6);
    @(posedge CLK_RE); #1;

    // Abort on the second symbol, coincident with symbol-done.
    cfg_send(0, 1, 0, 3, 14'b00000000000001, P_DMRS, 0);
    do_symbol(12, 0, P_FFT, 1);
    @(posedge CLK_RE); #1;
    Map_Wr_Valid = 1'b1;
    repeat (3) begin
      @(posedge CLK_RE); #1;
    end
    Map_Wr_Valid = 1'b0;
    Abort        = 1'b1;
    Map_Sym_Done = 1'b1;
    @(posedge CLK_RE); #1;
    Abort        = 1'b0;
    Map_Sym_Done = 1'b0;
    chk("abort_ready", Cfg_Ready, 1);
    chk("abort_busy", Busy, 0);
    repeat (3) begin
      @(posedge CLK_RE); #1;
    end
    // Abort held while idle must not block an accept.
    Abort = 1'b1;
    cfg_send(12, 1, 7, 7, 14'b00000010000000, P_DMRS, 7);
    Abort = 1'b0;
    chk("reaccept_n_sc", N_sc, 12);
    do_symbol(12, 0, P_DONE, 7);
    @(posedge CLK_RE); #1;

    // Watchdog: one write after ten idle cycles, then silence.
    cfg_send(0, 1, 0, 1, 14'b0, P_FFT, 0);
    repeat (10) begin
      @(posedge CLK_RE); #1;
    end
    Map_Wr_Valid = 1'b1;
    push(P_ETO, 0, cyc + 1 + 16);
    @(posedge CLK_RE); #1;
    Map_Wr_Valid = 1'b0;
    repeat (17) begin
      @(posedge CLK_RE); #1;
    end
    chk("timeout_busy", Busy, 0);
    chk("timeout_ready", Cfg_Ready, 1);

    // Asynchronous reset in the middle of a symbol.
    cfg_send(100, 3, 0, 2, 14'b00000000000001, P_DMRS, 0);
    @(posedge CLK_RE); #1;
    Map_Wr_Valid = 1'b1;
    repeat (5) begin
      @(posedge CLK_RE); #1;
    end
    #2;
    RST_RE = 1'b0;
    #1;
    chk("arst_busy", Busy, 0);
    chk("arst_ready", Cfg_Ready, 1);
    chk("arst_n_sc", N_sc, 0);
    chk("arst_n_rb", N_rb, 0);
    chk("arst_sym_is_dmrs", Sym_Is_Dmrs, 0);
    Map_Wr_Valid = 1'b0;
    repeat (2) @(posedge CLK_RE);
    #1;
    RST_RE = 1'b1;
    Map_Sym_Done = 1'b1;
    Map_Wr_Valid = 1'b1;
    @(posedge CLK_RE); #1;
    Map_Sym_Done = 1'b0;
    Map_Wr_Valid = 1'b0;
    repeat (3) begin
      @(posedge CLK_RE); #1;
    end
    chk("stray_done_busy", Busy, 0);
    chk("stray_done_sym_idx", Sym_Idx, 0);
    chk("pending_expectations", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
